// File: rtl/kbd_pkg.sv
// Shared definitions for the PS/2 set-2 keyboard event decoder:
// FSM state encoding and the scancodes the decoder treats specially.
package kbd_pkg;

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_EXT     = 3'd1,
      S_BRK     = 3'd2,
      S_EXT_BRK = 3'd3,
      S_OUT     = 3'd4
   } kbd_state_t;

   localparam logic [7:0] SC_NULL   = 8'h00;
   localparam logic [7:0] SC_E0     = 8'hE0;
   localparam logic [7:0] SC_F0     = 8'hF0;
   localparam logic [7:0] SC_LSHIFT = 8'h12;
   localparam logic [7:0] SC_RSHIFT = 8'h59;
   localparam logic [7:0] SC_CTRL   = 8'h14;
   localparam logic [7:0] SC_CAPS   = 8'h58;
   localparam logic [7:0] SC_SPACE  = 8'h29;
   localparam logic [7:0] SC_ENTER  = 8'h5A;
   localparam logic [7:0] SC_BKSP   = 8'h66;

endpackage

// File: rtl/scancode_ascii_rom.sv
// Combinational set-2 scancode to ASCII lookup (non-extended make codes only).
module scancode_ascii_rom
   import kbd_pkg::*;
(
   input  logic [7:0] code,
   input  logic       shift,
   input  logic       caps,
   input  logic       ctrl,
   output logic [7:0] ascii
);

   logic [7:0] letter;

   always_comb begin
      letter = 8'h00;
      case (code)
         8'h1C: letter = 8'h61;  8'h32: letter = 8'h62;  8'h21: letter = 8'h63;
         8'h23: letter = 8'h64;  8'h24: letter = 8'h65;  8'h2B: letter = 8'h66;
         8'h34: letter = 8'h67;  8'h33: letter = 8'h68;  8'h43: letter = 8'h69;
         8'h3B: letter = 8'h6A;  8'h42: letter = 8'h6B;  8'h4B: letter = 8'h6C;
         8'h3A: letter = 8'h6D;  8'h31: letter = 8'h6E;  8'h44: letter = 8'h6F;
         8'h4D: letter = 8'h70;  8'h15: letter = 8'h71;  8'h2D: letter = 8'h72;
         8'h1B: letter = 8'h73;  8'h2C: letter = 8'h74;  8'h3C: letter = 8'h75;
         8'h2A: letter = 8'h76;  8'h1D: letter = 8'h77;  8'h22: letter = 8'h78;
         8'h35: letter = 8'h79;  8'h1A: letter = 8'h7A;
         default: letter = 8'h00;
      endcase
   end

   always_comb begin
      ascii = 8'h00;
      if (letter != 8'h00) begin
         // Control characters take priority over case selection.
         if (ctrl)              ascii = letter - 8'h60;
         else if (shift ^ caps) ascii = letter - 8'h20;
         else                   ascii = letter;
      end else begin
         case (code)
            8'h45: ascii = 8'h30;  8'h16: ascii = 8'h31;  8'h1E: ascii = 8'h32;
            8'h26: ascii = 8'h33;  8'h25: ascii = 8'h34;  8'h2E: ascii = 8'h35;
            8'h36: ascii = 8'h36;  8'h3D: ascii = 8'h37;  8'h3E: ascii = 8'h38;
            8'h46: ascii = 8'h39;
            SC_SPACE: ascii = 8'h20;
            SC_ENTER: ascii = 8'h0D;
            SC_BKSP:  ascii = 8'h08;
            default:  ascii = 8'h00;
         endcase
      end
   end

endmodule

// File: rtl/kbd_event_decoder.sv
// Assembles PS/2 set-2 byte sequences (E0/F0 prefixes) into key events,
// tracking modifiers, a one-key typematic detector and a press counter.
module kbd_event_decoder
   import kbd_pkg::*;
(
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_data,
   output logic       in_ready,
   output logic       ev_valid,
   input  logic       ev_ready,
   output logic [7:0] ev_code,
   output logic       ev_ext,
   output logic       ev_press,
   output logic       ev_repeat,
   output logic [7:0] ev_ascii,
   output logic       shift,
   output logic       ctrl,
   output logic       caps,
   output logic [7:0] press_count
);

   kbd_state_t state_q, state_d;
   logic [7:0] code_q, code_d, ascii_q, ascii_d, count_q, count_d, held_code_q, held_code_d;
   logic       ext_q, ext_d, press_q, press_d, rep_q, rep_d;
   logic       held_vld_q, held_vld_d, held_ext_q, held_ext_d;
   logic       lshift_q, lshift_d, rshift_q, rshift_d, ctrl_q, ctrl_d, caps_q, caps_d;
   logic       pfx_ext, pfx_brk, is_make, is_rep;
   logic [7:0] rom_ascii;

   scancode_ascii_rom u_rom (
      .code  (in_data),
      .shift (lshift_q | rshift_q),
      .caps  (caps_q),
      .ctrl  (ctrl_q),
      .ascii (rom_ascii)
   );

   assign pfx_ext = (state_q == S_EXT) || (state_q == S_EXT_BRK);
   assign pfx_brk = (state_q == S_BRK) || (state_q == S_EXT_BRK);
   assign is_make = !pfx_brk;
   assign is_rep  = is_make && held_vld_q && (held_ext_q == pfx_ext) && (held_code_q == in_data);

   always_comb begin
      state_d     = state_q;
      code_d      = code_q;
      ascii_d     = ascii_q;
      ext_d       = ext_q;
      press_d     = press_q;
      rep_d       = rep_q;
      count_d     = count_q;
      held_vld_d  = held_vld_q;
      held_ext_d  = held_ext_q;
      held_code_d = held_code_q;
      lshift_d    = lshift_q;
      rshift_d    = rshift_q;
      ctrl_d      = ctrl_q;
      caps_d      = caps_q;
      if (state_q == S_OUT) begin
         if (ev_ready) state_d = S_IDLE;
      end else if (in_valid && in_data != SC_NULL) begin
         if (in_data == SC_E0) begin
            state_d = pfx_brk ? S_EXT_BRK : S_EXT;
         end else if (in_data == SC_F0) begin
            state_d = pfx_ext ? S_EXT_BRK : S_BRK;
         end else begin
            // Final byte: latch the event and apply all side effects on this edge.
            state_d = S_OUT;
            code_d  = in_data;
            ext_d   = pfx_ext;
            press_d = is_make;
            rep_d   = is_rep;
            ascii_d = (pfx_ext || pfx_brk) ? 8'h00 : rom_ascii;
            if (is_make) begin
               held_vld_d  = 1'b1;
               held_ext_d  = pfx_ext;
               held_code_d = in_data;
            end else if (held_vld_q && held_ext_q == pfx_ext && held_code_q == in_data) begin
               held_vld_d  = 1'b0;
            end
            if (is_make && !is_rep) count_d = count_q + 8'd1;
            if (!pfx_ext && in_data == SC_LSHIFT) lshift_d = is_make;
            if (!pfx_ext && in_data == SC_RSHIFT) rshift_d = is_make;
            if (in_data == SC_CTRL) ctrl_d = is_make;
            if (is_make && !is_rep && in_data == SC_CAPS) caps_d = !caps_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q     <= S_IDLE;
         code_q      <= 8'h00;
         ascii_q     <= 8'h00;
         ext_q       <= 1'b0;
         press_q     <= 1'b0;
         rep_q       <= 1'b0;
         count_q     <= 8'h00;
         held_vld_q  <= 1'b0;
         held_ext_q  <= 1'b0;
         held_code_q <= 8'h00;
         lshift_q    <= 1'b0;
         rshift_q    <= 1'b0;
         ctrl_q      <= 1'b0;
         caps_q      <= 1'b0;
      end else begin
         state_q     <= state_d;
         code_q      <= code_d;
         ascii_q     <= ascii_d;
         ext_q       <= ext_d;
         press_q     <= press_d;
         rep_q       <= rep_d;
         count_q     <= count_d;
         held_vld_q  <= held_vld_d;
         held_ext_q  <= held_ext_d;
         held_code_q <= held_code_d;
         lshift_q    <= lshift_d;
         rshift_q    <= rshift_d;
         ctrl_q      <= ctrl_d;
         caps_q      <= caps_d;
      end
   end

   assign in_ready    = (state_q != S_OUT);
   assign ev_valid    = (state_q == S_OUT);
   assign ev_code     = code_q;
   assign ev_ext      = ext_q;
   assign ev_press    = press_q;
   assign ev_repeat   = rep_q;
   assign ev_ascii    = ascii_q;
   assign shift       = lshift_q | rshift_q;
   assign ctrl        = ctrl_q;
   assign caps        = caps_q;
   assign press_count = count_q;

endmodule

// File: tb/tb_kbd_event_decoder.sv
// Directed-vector bench for kbd_event_decoder with hand-computed expectations.
module tb_kbd_event_decoder;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_data;
   logic       in_ready;
   logic       ev_valid;
   logic       ev_ready;
   logic [7:0] ev_code;
   logic       ev_ext;
   logic       ev_press;
   logic       ev_repeat;
   logic [7:0] ev_ascii;
   logic       shift;
   logic       ctrl;
   logic       caps;
   logic [7:0] press_count;

   int n_checks = 0;
   int n_pass   = 0;

   kbd_event_decoder dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_data     (in_data),
      .in_ready    (in_ready),
      .ev_valid    (ev_valid),
      .ev_ready    (ev_ready),
      .ev_code     (ev_code),
      .ev_ext      (ev_ext),
      .ev_press    (ev_press),
      .ev_repeat   (ev_repeat),
      .ev_ascii    (ev_ascii),
      .shift       (shift),
      .ctrl        (ctrl),
      .caps        (caps),
      .press_count (press_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      in_valid = 1'b0;
      ev_ready = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b);
      int n = 0;
      while (!in_ready && n < 20) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 20) check("send_rdy_timeout", in_ready, 1);
      in_valid = 1'b1;
      in_data  = b;
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'h00;
   endtask

   task automatic consume();
      ev_ready = 1'b1;
      @(posedge clk); #1;
      ev_ready = 1'b0;
   endtask

   task automatic expect_event(input string tag, input logic [7:0] code, input logic ext,
                               input logic press, input logic rep, input logic [7:0] asc);
      int n = 0;
      while (!ev_valid && n < 8) begin
         @(posedge clk); #1; n++;
      end
      check({tag, "_vld"},   ev_valid, 1);
      check({tag, "_code"},  ev_code, code);
      check({tag, "_ext"},   ev_ext, ext);
      check({tag, "_press"}, ev_press, press);
      check({tag, "_rep"},   ev_repeat, rep);
      check({tag, "_ascii"}, ev_ascii, asc);
      consume();
      check({tag, "_done"},  ev_valid, 0);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst = 1'b0; in_valid = 1'b0; in_data = 8'h00; ev_ready = 1'b0;
      do_reset();
      check("rst_evv", ev_valid, 0);
      check("rst_inr", in_ready, 1);
      check("rst_code", ev_code, 8'h00);
      check("rst_ascii", ev_ascii, 8'h00);
      check("rst_flags", {ev_ext, ev_press, ev_repeat}, 3'b000);
      check("rst_mods", {shift, ctrl, caps}, 3'b000);
      check("rst_cnt", press_count, 8'h00);

      // Single make
      send_byte(8'h1C);
      check("a_cnt_early", press_count, 1);
      expect_event("a", 8'h1C, 0, 1, 0, 8'h61);
      check("a_cnt", press_count, 1);

      // Shift + letter, then releases
      do_reset();
      send_byte(8'h12);
      check("sh_on", shift, 1);
      expect_event("sh_mk", 8'h12, 0, 1, 0, 8'h00);
      send_byte(8'h1C);
      expect_event("sh_A", 8'h1C, 0, 1, 0, 8'h41);
      send_byte(8'hF0); send_byte(8'h1C);
      expect_event("sh_brkA", 8'h1C, 0, 0, 0, 8'h00);
      send_byte(8'hF0); send_byte(8'h12);
      check("sh_off", shift, 0);
      expect_event("sh_brk", 8'h12, 0, 0, 0, 8'h00);
      check("sh_cnt", press_count, 2);

      // Extended break
      do_reset();
      send_byte(8'hE0); send_byte(8'hF0);
      check("eb_noev", ev_valid, 0);
      send_byte(8'h75);
      expect_event("eb", 8'h75, 1, 0, 0, 8'h00);
      check("eb_cnt", press_count, 0);

      // Null bytes discarded mid-sequence; extended make gets no ascii
      do_reset();
      send_byte(8'hE0); send_byte(8'h00);
      check("nul_noev", ev_valid, 0);
      send_byte(8'h1C);
      expect_event("nul_ext", 8'h1C, 1, 1, 0, 8'h00);

      // Typematic repeat and caps lock
      do_reset();
      send_byte(8'h1C);
      expect_event("rp1", 8'h1C, 0, 1, 0, 8'h61);
      send_byte(8'h1C);
      expect_event("rp2", 8'h1C, 0, 1, 1, 8'h61);
      check("rp_cnt", press_count, 1);
      send_byte(8'h58);
      check("caps_on", caps, 1);
      expect_event("caps", 8'h58, 0, 1, 0, 8'h00);
      send_byte(8'h1C);
      expect_event("capsA", 8'h1C, 0, 1, 0, 8'h41);
      check("caps_cnt", press_count, 3);

      // Ctrl + c, digit, space, enter, backspace
      do_reset();
      send_byte(8'h14);
      expect_event("ctl", 8'h14, 0, 1, 0, 8'h00);
      check("ctl_on", ctrl, 1);
      send_byte(8'h21);
      expect_event("ctl_c", 8'h21, 0, 1, 0, 8'h03);
      send_byte(8'hF0); send_byte(8'h14);
      expect_event("ctl_brk", 8'h14, 0, 0, 0, 8'h00);
      check("ctl_off", ctrl, 0);
      send_byte(8'h16); expect_event("dig1", 8'h16, 0, 1, 0, 8'h31);
      send_byte(8'h45); expect_event("dig0", 8'h45, 0, 1, 0, 8'h30);
      send_byte(8'h29); expect_event("spc", 8'h29, 0, 1, 0, 8'h20);
      send_byte(8'h5A); expect_event("ent", 8'h5A, 0, 1, 0, 8'h0D);
      send_byte(8'h66); expect_event("bks", 8'h66, 0, 1, 0, 8'h08);

      // Backpressure: event held while a new byte is offered
      do_reset();
      send_byte(8'h1C);
      in_valid = 1'b1; in_data = 8'h32;
      for (int i = 0; i < 10; i++) begin
         @(posedge clk); #1;
         check("bp_inr", in_ready, 0);
         check("bp_vld", ev_valid, 1);
         check("bp_code", {ev_code, ev_ascii, ev_press, ev_repeat, ev_ext}, {8'h1C, 8'h61, 3'b100});
      end
      in_valid = 1'b0; in_data = 8'h00;
      consume();
      check("bp_done", ev_valid, 0);
      check("bp_cnt", press_count, 1);

      // Counter wrap after 256 non-repeat makes
      do_reset();
      for (int i = 0; i < 256; i++) begin
         send_byte((i % 2 == 0) ? 8'h1C : 8'h32);
         consume();
         if (i == 254) check("wrap_ff", press_count, 8'hFF);
      end
      check("wrap_00", press_count, 8'h00);

      // Reset after E0 discards the prefix and all state
      do_reset();
      send_byte(8'h12); consume();
      send_byte(8'hE0);
      do_reset();
      check("mr_mods", {shift, ctrl, caps}, 3'b000);
      send_byte(8'h1C);
      expect_event("mr", 8'h1C, 0, 1, 0, 8'h61);
      check("mr_cnt", press_count, 1);

      // Reset with an event pending drops it
      send_byte(8'h32);
      do_reset();
      check("ro_vld", ev_valid, 0);
      check("ro_cnt", press_count, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
